// File: rtl/stream_demux_pkg.sv
// Shared limits, typedefs and sizing helpers for stream_demux.
package stream_demux_pkg;

   localparam int MAX_CH    = 16;
   localparam int MAX_DEPTH = 16;

   typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

   function automatic int ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Input stream plus per-channel output streams of stream_demux.
// Carries bcast only when STREAM_DEMUX_BCAST_EN is defined.
interface stream_demux_if #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 8
);
   import stream_demux_pkg::*;

   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        in_data;
   logic [SEL_W-1:0]         in_sel;
`ifdef STREAM_DEMUX_BCAST_EN
   logic                     bcast;
`endif
   logic [N_CH-1:0]          out_valid;
   logic [N_CH-1:0]          out_ready;
   logic [N_CH*DATA_W-1:0]   out_data;

`ifdef STREAM_DEMUX_BCAST_EN
   modport master (
      output in_valid, in_data, in_sel, bcast, out_ready,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_data, in_sel, bcast, out_ready,
      output in_ready, out_valid, out_data
   );
`else
   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data
   );
`endif

endinterface

// File: rtl/demux_ch_fifo.sv
// One output channel buffer of stream_demux: power-of-two FIFO
// whose head is held in a register so it resets to zero.
module demux_ch_fifo
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2,
   localparam int PW    = ptr_w(DEPTH),
   localparam int CW    = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count_nx;
   logic [CW-1:0]     left;
   logic              do_push;
   logic              do_pop;

   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & ~full;
   assign left     = count - CW'(do_pop);
   assign count_nx = left + CW'(do_push);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         dout   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_nx;
         full  <= (count_nx == CW'(DEPTH));
         // Head comes from din when the FIFO drains to empty this cycle.
         if (do_push && left == '0)
            dout <= din;
         else if (do_pop && count > CW'(1))
            dout <= mem[rd_ptr + PW'(1)];
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux with per-channel FIFOs.
// Broadcast routing is built when STREAM_DEMUX_BCAST_EN is defined.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   stream_demux_if.slave   bus,
   output logic            err_sel,
   output logic [N_CH-1:0] ch_full
);

   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW    = cnt_w(DEPTH);

   logic [N_CH-1:0] hit;
   logic [N_CH-1:0] room;
   logic [N_CH-1:0] push;
   logic [N_CH-1:0] pop;
   logic [N_CH-1:0] empty;
   logic [CW-1:0]   cnt [N_CH];
   logic            sel_ok;
   logic            is_bcast;
   logic            ready;
   logic            fire;

`ifdef STREAM_DEMUX_BCAST_EN
   assign is_bcast = bus.bcast;
`else
   assign is_bcast = 1'b0;
`endif

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign hit[k]  = (bus.in_sel == SEL_W'(k));
      assign room[k] = (cnt[k] < CW'(DEPTH));
      assign push[k] = fire & (is_bcast | hit[k]);
      assign pop[k]  = ~empty[k] & bus.out_ready[k];
      assign bus.out_valid[k] = ~empty[k];

      demux_ch_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[k]),
         .pop   (pop[k]),
         .din   (bus.in_data),
         .dout  (bus.out_data[k*DATA_W +: DATA_W]),
         .count (cnt[k]),
         .full  (ch_full[k]),
         .empty (empty[k])
      );
   end

   assign sel_ok = |hit;

   // Ready looks only at registered counts, never at out_ready.
   always_comb begin
      ready = 1'b1;
      if (is_bcast)
         ready = &room;
      else if (sel_ok)
         ready = |(hit & room);
   end

   assign bus.in_ready = ready;
   assign fire         = bus.in_valid & ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_sel <= 1'b0;
      else        err_sel <= fire & ~sel_ok & ~is_bcast;
   end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux against a queue-based model.
// Broadcast scenarios run when STREAM_DEMUX_BCAST_EN is defined.
module tb_stream_demux;
   import stream_demux_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   int         n_checks = 0;
   int         n_fail   = 0;

   logic       drv_valid;
   logic [7:0] drv_data;
   logic [1:0] drv_sel;
   logic       drv_bcast;
   logic [3:0] drv_ready;
   logic       use_b;

   stream_demux_if #(.N_CH(4), .DATA_W(8)) ifa ();
   stream_demux_if #(.N_CH(3), .DATA_W(8)) ifb ();

   logic       err_a, err_b;
   logic [3:0] full_a;
   logic [2:0] full_b;

   stream_demux #(.N_CH(4), .DATA_W(8), .DEPTH(DEPTH)) dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (ifa),
      .err_sel (err_a),
      .ch_full (full_a)
   );

   stream_demux #(.N_CH(3), .DATA_W(8), .DEPTH(DEPTH)) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (ifb),
      .err_sel (err_b),
      .ch_full (full_b)
   );

   assign ifa.in_valid  = drv_valid & ~use_b;
   assign ifa.in_data   = drv_data;
   assign ifa.in_sel    = drv_sel;
   assign ifa.out_ready = drv_ready;
   assign ifb.in_valid  = drv_valid & use_b;
   assign ifb.in_data   = drv_data;
   assign ifb.in_sel    = drv_sel;
   assign ifb.out_ready = drv_ready[2:0];
`ifdef STREAM_DEMUX_BCAST_EN
   assign ifa.bcast = drv_bcast;
   assign ifb.bcast = drv_bcast;
`endif

   logic        obs_ready, obs_err;
   logic [3:0]  obs_valid, obs_full;
   logic [31:0] obs_data;

   always_comb begin
      if (use_b) begin
         obs_ready = ifb.in_ready;
         obs_valid = {1'b0, ifb.out_valid};
         obs_data  = {8'h00, ifb.out_data};
         obs_full  = {1'b0, full_b};
         obs_err   = err_b;
      end else begin
         obs_ready = ifa.in_ready;
         obs_valid = ifa.out_valid;
         obs_data  = ifa.out_data;
         obs_full  = full_a;
         obs_err   = err_a;
      end
   end

   // Reference model: one queue per channel.
   int         n_ch = 4;
   logic [7:0] q [4][$];
   bit         exp_err;

   function automatic bit m_ready();
      bit r = 1'b1;
      if (drv_bcast) begin
         for (int k = 0; k < n_ch; k++)
            if (q[k].size() >= DEPTH) r = 1'b0;
      end else if (int'(drv_sel) < n_ch) begin
         r = (q[drv_sel].size() < DEPTH);
      end
      return r;
   endfunction

   function automatic logic [3:0] m_valid();
      logic [3:0] v = '0;
      for (int k = 0; k < n_ch; k++) v[k] = (q[k].size() != 0);
      return v;
   endfunction

   function automatic logic [3:0] m_full();
      logic [3:0] f = '0;
      for (int k = 0; k < n_ch; k++) f[k] = (q[k].size() == DEPTH);
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) q[k].delete();
      exp_err = 1'b0;
   endtask

   task automatic advance(output bit acc);
      bit pop [4];
      acc = drv_valid && m_ready();
      for (int k = 0; k < 4; k++)
         pop[k] = (k < n_ch) && q[k].size() > 0 && drv_ready[k];
      @(posedge clk);
      for (int k = 0; k < 4; k++)
         if (pop[k]) void'(q[k].pop_front());
      exp_err = acc && !drv_bcast && int'(drv_sel) >= n_ch;
      if (acc) begin
         if (drv_bcast) begin
            for (int k = 0; k < n_ch; k++) q[k].push_back(drv_data);
         end else if (int'(drv_sel) < n_ch) begin
            q[drv_sel].push_back(drv_data);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drv_valid = 0; drv_sel = 0; drv_data = 0;
      drv_ready = 0; drv_bcast = 0; use_b = 0;
      n_ch = 4;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_valid got %b exp 0000", obs_valid);
      end
      n_checks++;
      if (obs_full !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_full got %b exp 0000", obs_full);
      end
      n_checks++;
      if (obs_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err got %b exp 0", obs_err);
      end
      n_checks++;
      if (obs_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data got %h exp 0", obs_data);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      bit acc;
      drv_valid = 1; drv_sel = 2; drv_data = 8'hA5; drv_ready = 0;
      @(negedge clk);
      n_checks++;
      if (obs_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready got %b exp 1", obs_ready);
      end
      advance(acc);
      drv_valid = 0;
      @(negedge clk);
      n_checks++;
      if (obs_valid !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_valid got %b exp 0100", obs_valid);
      end
      n_checks++;
      if (obs_data[23:16] !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_data got %h exp a5", obs_data[23:16]);
      end
      drv_ready = 4'hF;
      advance(acc);
      @(negedge clk);
      n_checks++;
      if (obs_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_drain got %b exp 0000", obs_valid);
      end
      drv_ready = 0;
      advance(acc);
   endtask

   task automatic test_backpressure();
      bit acc;
      logic [7:0] exp_d [3];
      bit         exp_r [3];
      exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
      exp_r[0] = 1'b1;  exp_r[1] = 1'b1;  exp_r[2] = 1'b0;
      drv_ready = 0; drv_sel = 1; drv_valid = 1;
      for (int i = 0; i < 3; i++) begin
         drv_data = exp_d[i];
         @(negedge clk);
         n_checks++;
         if (obs_ready !== exp_r[i]) begin
            n_fail++;
            $display("FAIL bp_ready beat %0d got %b exp %b",
                     i, obs_ready, exp_r[i]);
         end
         if (i < 2) advance(acc);
      end
      n_checks++;
      if (obs_full[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_full got %b exp 1", obs_full[1]);
      end
      advance(acc);
      drv_ready = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_valid[1] !== 1'b1 || obs_data[15:8] !== exp_d[i]) begin
            n_fail++;
            $display("FAIL bp_pop %0d got v=%b d=%h exp v=1 d=%h",
                     i, obs_valid[1], obs_data[15:8], exp_d[i]);
         end
         n_checks++;
         if (obs_ready !== (i == 1 ? 1'b1 : i == 0 ? 1'b0 : 1'b1)) begin
            n_fail++;
            $display("FAIL bp_ready2 %0d got %b", i, obs_ready);
         end
         advance(acc);
         if (i == 1) drv_valid = 0;
      end
      @(negedge clk);
      n_checks++;
      if (obs_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL bp_empty got %b exp 0000", obs_valid);
      end
      drv_ready = 0;
      advance(acc);
   endtask

   task automatic test_full_pop_push();
      bit acc;
      logic [7:0] x;
      drv_ready = 0; drv_sel = 0; drv_valid = 1;
      for (int i = 0; i < 2; i++) begin
         drv_data = 8'($urandom);
         @(negedge clk);
         advance(acc);
      end
      x = 8'($urandom);
      drv_data = x; drv_ready = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (obs_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fpp_refuse got %b exp 0", obs_ready);
      end
      advance(acc);
      @(negedge clk);
      n_checks++;
      if (obs_ready !== 1'b1 || obs_full[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL fpp_accept got r=%b f=%b exp r=1 f=0",
                  obs_ready, obs_full[0]);
      end
      advance(acc);
      drv_valid = 0; drv_ready = 0;
      @(negedge clk);
      n_checks++;
      if (obs_valid[0] !== 1'b1 || obs_data[7:0] !== x) begin
         n_fail++;
         $display("FAIL fpp_head got v=%b d=%h exp v=1 d=%h",
                  obs_valid[0], obs_data[7:0], x);
      end
      drv_ready = 4'hF;
      advance(acc);
      drv_ready = 0;
   endtask

   task automatic test_stream_stall();
      bit acc;
      int got = 0;
      drv_ready = 0; drv_sel = 3; drv_valid = 1;
      for (int i = 0; i < 2; i++) begin
         drv_data = 8'($urandom);
         @(negedge clk);
         advance(acc);
      end
      drv_sel = 0; drv_ready = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         drv_data = 8'($urandom);
         @(negedge clk);
         n_checks++;
         if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_rate beat %0d got %b exp 1", i, obs_ready);
         end
         n_checks++;
         if (obs_valid[3] !== 1'b1 || obs_data[31:24] !== q[3][0]) begin
            n_fail++;
            $display("FAIL stall_ch3 got v=%b d=%h exp v=1 d=%h",
                     obs_valid[3], obs_data[31:24], q[3][0]);
         end
         if (q[0].size() != 0) begin
            n_checks++;
            if (obs_valid[0] !== 1'b1 || obs_data[7:0] !== q[0][0]) begin
               n_fail++;
               $display("FAIL stall_ch0 got v=%b d=%h exp v=1 d=%h",
                        obs_valid[0], obs_data[7:0], q[0][0]);
            end
         end
         advance(acc);
         if (acc) got++;
      end
      n_checks++;
      if (got != 20) begin
         n_fail++;
         $display("FAIL stall_count got %0d exp 20", got);
      end
      drv_valid = 0; drv_ready = 4'hF;
      repeat (3) begin
         @(negedge clk);
         advance(acc);
      end
      drv_ready = 0;
   endtask

   task automatic test_random(input int cycles, input int sel_max);
      bit acc = 1'b1;
      logic [3:0] v, f;
      for (int c = 0; c < cycles; c++) begin
         if (acc || !drv_valid) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_sel   = 2'($urandom_range(0, sel_max));
            drv_data  = 8'($urandom);
         end
         drv_ready = 4'($urandom);
         @(negedge clk);
         v = m_valid();
         f = m_full();
         n_checks++;
         if (obs_ready !== m_ready()) begin
            n_fail++;
            $display("FAIL rnd_ready cyc %0d got %b exp %b",
                     c, obs_ready, m_ready());
         end
         n_checks++;
         if (obs_valid !== v) begin
            n_fail++;
            $display("FAIL rnd_valid cyc %0d got %b exp %b", c, obs_valid, v);
         end
         n_checks++;
         if (obs_full !== f) begin
            n_fail++;
            $display("FAIL rnd_full cyc %0d got %b exp %b", c, obs_full, f);
         end
         n_checks++;
         if (obs_err !== exp_err) begin
            n_fail++;
            $display("FAIL rnd_err cyc %0d got %b exp %b", c, obs_err, exp_err);
         end
         for (int k = 0; k < n_ch; k++) begin
            if (v[k]) begin
               n_checks++;
               if (obs_data[k*8 +: 8] !== q[k][0]) begin
                  n_fail++;
                  $display("FAIL rnd_data cyc %0d ch %0d got %h exp %h",
                           c, k, obs_data[k*8 +: 8], q[k][0]);
               end
            end
         end
         advance(acc);
      end
      drv_valid = 0;
   endtask

   task automatic test_bad_sel();
      bit acc;
      use_b = 1; n_ch = 3; drv_ready = 0;
      model_reset();
      drv_valid = 1; drv_sel = 3; drv_data = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_ready got %b exp 1", obs_ready);
      end
      advance(acc);
      drv_valid = 0;
      @(negedge clk);
      n_checks++;
      if (obs_err !== 1'b1 || obs_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL bad_err got e=%b v=%b exp e=1 v=0000",
                  obs_err, obs_valid);
      end
      advance(acc);
      @(negedge clk);
      n_checks++;
      if (obs_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_pulse got %b exp 0", obs_err);
      end
      advance(acc);
      test_random(200, 3);
   endtask

`ifdef STREAM_DEMUX_BCAST_EN
   task automatic test_bcast();
      bit acc;
      drv_ready = 0; drv_bcast = 0; drv_sel = 2; drv_valid = 1;
      for (int i = 0; i < 2; i++) begin
         drv_data = 8'($urandom);
         @(negedge clk);
         advance(acc);
      end
      drv_bcast = 1; drv_data = 8'h3C; drv_sel = 2'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bc_blocked got %b exp 0", obs_ready);
      end
      advance(acc);
      drv_ready = 4'b0100;
      @(negedge clk);
      advance(acc);
      @(negedge clk);
      n_checks++;
      if (obs_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bc_accept got %b exp 1", obs_ready);
      end
      advance(acc);
      drv_valid = 0; drv_bcast = 0; drv_ready = 0;
      @(negedge clk);
      n_checks++;
      if (obs_valid !== 4'b1111 || obs_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bc_valid got v=%b e=%b exp v=1111 e=0",
                  obs_valid, obs_err);
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs_data[k*8 +: 8] !== 8'h3C) begin
            n_fail++;
            $display("FAIL bc_data ch %0d got %h exp 3c",
                     k, obs_data[k*8 +: 8]);
         end
      end
      advance(acc);
   endtask
`endif

   task automatic test_reset_mid();
      bit acc;
      drv_ready = 0; drv_valid = 1;
      for (int i = 0; i < 3; i++) begin
         drv_sel = (i == 2) ? 2'd3 : 2'd1;
         drv_data = 8'($urandom);
         @(negedge clk);
         advance(acc);
      end
      drv_valid = 0;
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (obs_valid !== 4'b0000 || obs_full !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_reset got v=%b f=%b exp 0000",
                  obs_valid, obs_full);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drv_ready = 4'hF;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (obs_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset got %b exp 0000", obs_valid);
         end
         advance(acc);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_full_pop_push();
      test_stream_stall();
      test_random(300, 3);
      test_reset_mid();
      test_bad_sel();
      test_reset();
`ifdef STREAM_DEMUX_BCAST_EN
      test_bcast();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking and a per-channel output FIFO. It supersedes the combinational 1-to-4 decoder-style demux for datapaths that need back-pressure, arbitrary data width and channel count. Each input beat is routed by a select field to one of N output channels, buffered there, and drained independently per channel.

## Interface
Parameters:
- `N_CH`, 4: number of output channels, 2..16.
- `DATA_W`, 8: payload width, 1..64.
- `DEPTH`, 2: entries per channel FIFO, power of two, 2..16.
- `SEL_W`, derived as $clog2(N_CH): select width. Not overridable.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: input beat accepted this cycle when high together with `in_valid`.
- `in_data`, in, DATA_W: payload.
- `in_sel`, in, SEL_W: destination channel index.
- `bcast`, in, 1: broadcast request. Present only with `STREAM_DEMUX_BCAST_EN`.
- `out_valid`, out, N_CH: per-channel valid.
- `out_ready`, in, N_CH: per-channel ready.
- `out_data`, out, N_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- `err_sel`, out, 1: one-cycle pulse when a beat with an out-of-range `in_sel` is accepted and dropped.
- `ch_full`, out, N_CH: per-channel FIFO full flag, registered.

## Operation
- Each channel has a FIFO with registered `count` (0..DEPTH), `wr_ptr` and `rd_ptr`. Pointers wrap at DEPTH.
- `in_ready` is 1 when `in_sel` is valid and `count[in_sel] < DEPTH`. It is also 1 when `in_sel >= N_CH`: the beat is dropped and `err_sel` pulses on the next cycle.
- `in_ready` depends only on registered counts and `in_sel`. There is no combinational path from `out_ready` to `in_ready`. A full channel whose head is popped in the same cycle does not accept a new beat that cycle.
- Push and pop on the same channel in the same cycle leaves `count` unchanged, and both pointers advance.
- `out_valid[k]` is 1 when `count[k] != 0`. `out_data` slice k is the FIFO head. When `count[k]` is 0, the slice holds its last value and is don't-care.
- A pop occurs when `out_valid[k] & out_ready[k]`. Channels drain independently, and order within a channel is strictly FIFO.
- Under back-pressure, a held beat keeps `in_data` and `in_sel` stable. Changing them while `in_valid` is high and `in_ready` is low is a protocol violation. The block does not check for it.
- Reset values: all counts and pointers 0, `out_valid` 0, `ch_full` 0, `err_sel` 0. `out_data` is 0; the FIFO storage is not reset.
- Reset asserted mid-transfer discards all buffered beats. No beat is emitted after reset until a new push occurs.

## Timing
- Latency: a beat accepted at edge t is visible at `out_valid`/`out_data` after edge t, so it is poppable in cycle t+1.
- Throughput: one input beat per cycle while the target channel is not full. A channel with DEPTH ≥ 2 sustains full rate with continuous `out_ready`.
- `ch_full[k]` and `err_sel` are registered and update one edge after the causing event.

## Configuration
- `STREAM_DEMUX_BCAST_EN` defined:
  - Adds the `bcast` port.
  - When `bcast` is 1, `in_sel` is ignored, and `in_ready` is 1 only if every channel has `count < DEPTH`.
  - An accepted broadcast beat is pushed into all N_CH FIFOs in the same cycle.
  - `err_sel` never pulses for a broadcast beat.
- Not defined:
  - No `bcast` port exists.
  - Routing is unicast only, exactly as described in Operation.

## Structure
- Shared package `stream_demux_pkg`:
  - Limits `MAX_CH` = 16, `MAX_DEPTH` = 16.
  - Function `ptr_w(depth)`.
  - Channel-index typedef sized for `MAX_CH`.
- One sub-module, `demux_ch_fifo`:
  - Parameters DATA_W and DEPTH.
  - Ports: push, pop, data in and out, `count`, `full`, `empty`; async active-low reset.
  - The top instantiates N_CH copies in a generate loop and adds the select decode, ready logic and `err_sel` register.

## Test plan
- Reset, then one beat `in_sel`=2, `in_data`=0xA5 → `out_valid`=4'b0100 and slice 2 = 0xA5 one cycle after acceptance; other `out_valid` bits stay 0.
- Hold `out_ready[1]`=0 and push 3 beats to channel 1 (DEPTH=2) → first two accepted, `ch_full[1]`=1, `in_ready`=0 on the third. Raise `out_ready[1]` → pops 0x01 then 0x02, and the third beat is then accepted.
- Full channel 0, pop and push in the same cycle → push refused that cycle, `count` goes 2→1, push accepted next cycle.
- Channel 3 stalled while beats stream to channel 0 → channel 0 sustains 1 beat/cycle with data in order, with no effect from channel 3.
- N_CH=3, `in_sel`=3 → `in_ready`=1, no channel pushed, `err_sel` high for exactly one cycle.
- `STREAM_DEMUX_BCAST_EN`, `bcast`=1, `in_data`=0x3C with channel 2 full → `in_ready`=0. Drain channel 2 → beat accepted, and all channels show 0x3C. Assert `rst_n`=0 mid-stream → all `out_valid` 0 immediately.
